alu_seq: RTL and testbench

- Parametrised multi-cycle ALU. It is the next-generation execute unit of the simple processor datapath.
- Adds configurable width, SUB/shift/MUL operations, a registered ZERO flag and a START/READY/VALID handshake.
- Single-cycle ops keep full throughput. Shifts and MUL run iteratively and stall the issuer via READY.

---
 rtl/alu_seq_if.sv | 37 +++
 rtl/alu_seq.sv | 211 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bus of the sequential ALU.
// master = issuer (drives operands and start), slave = the ALU.
// When ALU_FLAGS_EN is defined the bus also carries the carry/overflow flags.
interface alu_seq_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [2:0]        select;
  logic              start;
  logic              ready;
  logic [DATA_W-1:0] result;
  logic              valid;
  logic              zero;
`ifdef ALU_FLAGS_EN
  logic              carry;
  logic              overflow;

  modport master (
    output data1, data2, select, start,
    input  ready, result, valid, zero, carry, overflow
  );
  modport slave (
    input  data1, data2, select, start,
    output ready, result, valid, zero, carry, overflow
  );
`else
  modport master (
    output data1, data2, select, start,
    input  ready, result, valid, zero
  );
  modport slave (
    input  data1, data2, select, start,
    output ready, result, valid, zero
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// alu_seq: parametrised multi-cycle ALU with a start/ready/valid handshake.
// FORWARD/ADD/AND/OR/SUB (and shifts by 0) complete at the accept edge, so
// back-to-back requests give one result per cycle. SLL/SRA shift one bit per
// cycle and MUL is a shift-add over DATA_W cycles; ready drops while busy.
// DATA_W legal range: 4..32.
// Optional macro ALU_FLAGS_EN adds registered carry/overflow outputs.
module alu_seq #(
  parameter int DATA_W = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] SHIFT_SAT = DATA_W'(DATA_W);

  typedef enum logic [2:0] {
    OP_FWD = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SUB = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Request decode
  op_e               op_in;
  logic [DATA_W-1:0] amount;
  logic [DATA_W-1:0] quick_res;
  logic              multi;

  // Registered state
  state_e            state;
  logic              ready_q;
  logic              valid_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [CNT_W-1:0]  cnt;
  op_e               op_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc_next;

  assign op_in = op_e'(bus.select);

  // Decode the incoming request: single-cycle result, saturated shift amount,
  // and whether the op needs the iterative engine.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    quick_res = '0;
    multi     = 1'b0;
    amount    = (bus.data2 >= SHIFT_SAT) ? SHIFT_SAT : bus.data2;
    case (op_in)
      OP_FWD:  quick_res = bus.data2;
      OP_ADD:  quick_res = bus.data1 + bus.data2;
      OP_AND:  quick_res = bus.data1 & bus.data2;
      OP_OR:   quick_res = bus.data1 | bus.data2;
      OP_SUB:  quick_res = bus.data1 - bus.data2;
      OP_SLL,
      OP_SRA: begin
        // A zero shift is just the operand, so it completes immediately.
        quick_res = bus.data1;
        multi     = (amount != '0);
      end
      OP_MUL:  multi = 1'b1;
      default: quick_res = '0;
    endcase
  end

  // One step of the iterative engine: a single-bit shift, or one shift-add
  // partial product for MUL (acc holds the running product).
  always_comb begin
    acc_next = acc;
    case (op_q)
      OP_SLL:  acc_next = {acc[DATA_W-2:0], 1'b0};
      OP_SRA:  acc_next = {acc[DATA_W-1], acc[DATA_W-1:1]};
      default: acc_next = acc + (mplier[0] ? mcand : '0);
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;
  logic            quick_c;
  logic            quick_v;
  logic            carry_q;
  logic            overflow_q;

  // Carry/overflow of the single-cycle ADD/SUB; zero for every other op.
  always_comb begin
    sum_ext  = {1'b0, bus.data1} + {1'b0, bus.data2};
    diff_ext = {1'b0, bus.data1} - {1'b0, bus.data2};
    quick_c  = 1'b0;
    quick_v  = 1'b0;
    case (op_in)
      OP_ADD: begin
        quick_c = sum_ext[DATA_W];
        quick_v = (bus.data1[DATA_W-1] == bus.data2[DATA_W-1]) &&
                  (sum_ext[DATA_W-1] != bus.data1[DATA_W-1]);
      end
      OP_SUB: begin
        // Bit DATA_W of the zero-extended difference is the borrow.
        quick_c = ~diff_ext[DATA_W];
        quick_v = (bus.data1[DATA_W-1] != bus.data2[DATA_W-1]) &&
                  (diff_ext[DATA_W-1] != bus.data1[DATA_W-1]);
      end
      default: begin
        quick_c = 1'b0;
        quick_v = 1'b0;
      end
    endcase
  end

  // Flags are written together with result and cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state == S_IDLE && bus.start && !multi) begin
      carry_q    <= quick_c;
      overflow_q <= quick_v;
    end else if (state == S_BUSY && cnt == '0) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end
  end

  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
`endif

  // Control FSM and datapath registers: accept, iterate, complete.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: datapath registers are reset too, so an aborted op leaves no
      // stale operand or partial product behind.
      state    <= S_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt      <= '0;
      op_q     <= OP_FWD;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (multi) begin
              state   <= S_BUSY;
              ready_q <= 1'b0;
              op_q    <= op_in;
              mcand   <= bus.data1;
              mplier  <= bus.data2;
              if (op_in == OP_MUL) begin
                acc <= '0;
                cnt <= CNT_W'(DATA_W - 1);
              end else begin
                acc <= bus.data1;
                cnt <= CNT_W'(amount - 1'b1);
              end
            end else begin
              result_q <= quick_res;
              zero_q   <= (quick_res == '0);
              valid_q  <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) begin
            state    <= S_IDLE;
            ready_q  <= 1'b1;
            result_q <= acc_next;
            zero_q   <= (acc_next == '0);
            valid_q  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (DATA_W = 8).
// Expected results are pushed to a scoreboard queue when a request is driven
// and popped by a monitor on every valid pulse.
module tb_alu_seq;

  localparam int W = 8;

  localparam logic [2:0] FWD = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] SUB = 3'b100;
  localparam logic [2:0] SLL = 3'b101;
  localparam logic [2:0] SRA = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         c;
    logic         v;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];

  alu_seq_if #(.DATA_W(W)) bus ();

  alu_seq #(.DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one operation.
  function automatic exp_t model(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   w;
    logic [2*W-1:0] p;
    int           sh;
    e  = '0;
    sh = (int'(b) >= W) ? W : int'(b);
    case (sel)
      FWD: e.res = b;
      ADD: begin
        w     = {1'b0, a} + {1'b0, b};
        e.res = w[W-1:0];
        e.c   = w[W];
        e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      AND: e.res = a & b;
      OR:  e.res = a | b;
      SUB: begin
        e.res = a - b;
        e.c   = (a >= b);
        e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      SLL: e.res = (sh >= W) ? '0 : (a << sh);
      SRA: e.res = W'($signed(a) >>> sh);
      default: begin
        p     = (2*W)'(a) * (2*W)'(b);
        e.res = p[W-1:0];
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Present a request (start held high) and record its expected result.
  task automatic drive(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.select = sel;
    bus.data1  = a;
    bus.data2  = b;
    sb.push_back(model(sel, a, b));
  endtask

  // Drive a request for exactly the accept edge; returns 1 ns after it.
  task automatic issue(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(sel, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called 1 ns after the accept edge (edge 1). Returns the edge number after
  // which valid is seen and how many of those cycles had ready low.
  task automatic wait_valid(output int k, output int low);
    k   = 1;
    low = 0;
    while (bus.valid !== 1'b1 && k < 40) begin
      if (bus.ready === 1'b0) low++;
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Scoreboard monitor: compare every completion against the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("valid_without_request", 32'(bus.valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(bus.result), 32'(e.res));
        check("zero", 32'(bus.zero), 32'(e.zero));
`ifdef ALU_FLAGS_EN
        check("carry", 32'(bus.carry), 32'(e.c));
        check("overflow", 32'(bus.overflow), 32'(e.v));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int low;
    int spurious;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.select = '0;
    bus.data1  = '0;
    bus.data2  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops: 0x80 / 0x00 / 0xFF on consecutive cycles.
    drive(ADD, 8'h7F, 8'h01);
    @(posedge clk); #1;
    check("b2b_valid_1", 32'(bus.valid), 32'd1);
    check("b2b_ready_1", 32'(bus.ready), 32'd1);
    drive(SUB, 8'h05, 8'h05);
    @(posedge clk); #1;
    check("b2b_valid_2", 32'(bus.valid), 32'd1);
    check("b2b_ready_2", 32'(bus.ready), 32'd1);
    drive(OR, 8'hF0, 8'h0F);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_valid_3", 32'(bus.valid), 32'd1);
    check("b2b_ready_3", 32'(bus.ready), 32'd1);
    @(posedge clk); #1;

    // MUL 13*11 = 0x8F: ready low 8 cycles, valid after edge 9.
    issue(MUL, 8'd13, 8'd11);
    wait_valid(k, low);
    check("mul_latency", 32'(k), 32'd9);
    check("mul_ready_low", 32'(low), 32'd8);

    // MUL 0x10*0x10 wraps to zero.
    issue(MUL, 8'h10, 8'h10);
    wait_valid(k, low);
    check("mul_wrap_latency", 32'(k), 32'd9);

    // SRA 0x90 by 3 = 0xF2, valid after edge 4.
    issue(SRA, 8'h90, 8'd3);
    wait_valid(k, low);
    check("sra3_latency", 32'(k), 32'd4);
    check("sra3_ready_low", 32'(low), 32'd3);

    // SLL by 9 saturates to 8: result 0, valid after edge 9.
    issue(SLL, 8'h01, 8'd9);
    wait_valid(k, low);
    check("sll_sat_latency", 32'(k), 32'd9);

    // SRA by a large amount gives all sign bits.
    issue(SRA, 8'h80, 8'hC8);
    wait_valid(k, low);
    check("sra_sat_latency", 32'(k), 32'd9);

    // Remaining single-cycle opcodes.
    issue(FWD, 8'h11, 8'hAA);
    wait_valid(k, low);
    check("fwd_latency", 32'(k), 32'd1);
    issue(AND, 8'hF0, 8'h3C);
    wait_valid(k, low);
    check("and_latency", 32'(k), 32'd1);

    // Request held during a MUL is ignored until the valid cycle, then accepted.
    issue(MUL, 8'd7, 8'd9);
    drive(ADD, 8'h20, 8'h22);
    wait_valid(k, low);
    check("busy_mul_latency", 32'(k), 32'd9);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("held_req_valid", 32'(bus.valid), 32'd1);
    check("held_req_ready", 32'(bus.ready), 32'd1);
    @(posedge clk); #1;

    // Reset at edge 4 of a MUL aborts it without a valid pulse.
    issue(MUL, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_valid", 32'(bus.valid), 32'd0);
    check("abort_zero", 32'(bus.zero), 32'd0);
    spurious = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.valid !== 1'b0) spurious++;
    end
    check("abort_no_valid", 32'(spurious), 32'd0);

    issue(ADD, 8'd2, 8'd3);
    wait_valid(k, low);
    check("post_abort_add_latency", 32'(k), 32'd1);

    // Shift by zero is single-cycle and ready never drops.
    issue(SLL, 8'h3C, 8'd0);
    wait_valid(k, low);
    check("sll0_latency", 32'(k), 32'd1);
    check("sll0_ready_low", 32'(low), 32'd0);
    check("sll0_ready", 32'(bus.ready), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
